// File: rtl/mp_ram_pkg.sv
// mp_ram_pkg: shared constants and types for the multi-port RAM.
//   DEFAULT_*      default parameter values for mp_ram and mp_ram_if
//   MAX_PORTS      largest supported port count
//   port_idx_t     index of one access port (wide enough for MAX_PORTS)
//   rr_ptr_width() width of the round-robin pointer for a given port count
package mp_ram_pkg;

    localparam int DEFAULT_NUM_PORTS  = 2;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_BUS_WIDTH  = 64;
    localparam int MAX_PORTS          = 8;

    typedef logic [2:0] port_idx_t;

    // A single port still needs a 1-bit pointer so the register is legal.
    function automatic int rr_ptr_width(input int num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/mp_ram_if.sv
// mp_ram_if: request/response bundle between a requester and mp_ram.
//   en          global enable (requester -> RAM)
//   req_*       per-port request channel: valid, ready, we, addr, wdata
//   rsp_*       per-port read response channel: valid, ready, rdata
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both 1 for that port. Request ready is combinational in the RAM and
// may drop without a transfer; a response, once valid, holds valid and data
// stable until the edge on which rsp_ready is also 1.
interface mp_ram_if
    import mp_ram_pkg::*;
#(
    parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH
);
    logic                            en;
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*BUS_WIDTH-1:0]  req_wdata;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [NUM_PORTS-1:0]            rsp_ready;
    logic [NUM_PORTS*BUS_WIDTH-1:0]  rsp_rdata;

    modport master (
        output en, req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  en, req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mp_ram_arb.sv
// mp_ram_arb: write-write collision arbiter.
//   valid     per-port request valid (already qualified by the global enable)
//   we        per-port write flag
//   addr      per-port address, port p at slice p
//   rr_ptr    round-robin start port
//   arb_loss  per-port: a write that lost to another write on the same address
//   winner    first colliding-group winner in cyclic order from rr_ptr
//   collision 1 when any write lost this cycle
module mp_ram_arb
    import mp_ram_pkg::*;
#(
    parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic [NUM_PORTS-1:0]            valid,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  port_idx_t                       rr_ptr,
    output logic [NUM_PORTS-1:0]            arb_loss,
    output port_idx_t                       winner,
    output logic                            collision
);

    logic [NUM_PORTS-1:0] wr;
    logic [NUM_PORTS-1:0] paired;
    int                   best;

    // Distance of port p from the round-robin start, walking upward mod N.
    function automatic int cdist(input int p, input int r);
        return (p >= r) ? (p - r) : (p + NUM_PORTS - r);
    endfunction

    assign wr = valid & we;

    always_comb begin
        arb_loss  = '0;
        paired    = '0;
        winner    = rr_ptr;
        best      = NUM_PORTS;
        // A write loses if another write to the same address sits closer
        // to rr_ptr in cyclic order.
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q != p && wr[p] && wr[q] &&
                    addr[p*ADDR_WIDTH +: ADDR_WIDTH] == addr[q*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    paired[p] = 1'b1;
                    if (cdist(q, int'(rr_ptr)) < cdist(p, int'(rr_ptr)))
                        arb_loss[p] = 1'b1;
                end
            end
        end
        collision = |arb_loss;
        // Of the ports that won a contested address, take the one nearest
        // rr_ptr; the pointer moves just past it.
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (paired[p] && !arb_loss[p] && cdist(p, int'(rr_ptr)) < best) begin
                best   = cdist(p, int'(rr_ptr));
                winner = port_idx_t'(p);
            end
        end
    end

endmodule

// File: rtl/mp_ram.sv
// mp_ram: multi-port RAM, one read or write per port per cycle.
//   clk       rising-edge clock
//   areset    asynchronous active-high reset (memory contents not reset)
//   bus       mp_ram_if slave: en, req_* request channel, rsp_* read channel
//   coll_cnt  (only with MP_RAM_COLLISION_CNT_EN) saturating count of cycles
//             that had at least one write-write collision
// Reads are read-first against same-edge writes; same-address writes are
// resolved round-robin by mp_ram_arb.
module mp_ram
    import mp_ram_pkg::*;
#(
    parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH
) (
    input  logic         clk,
    input  logic         areset,
    mp_ram_if.slave      bus
`ifdef MP_RAM_COLLISION_CNT_EN
    ,
    output logic [15:0]  coll_cnt
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int RR_W  = rr_ptr_width(NUM_PORTS);

    logic [BUS_WIDTH-1:0]           mem [DEPTH];
    logic [RR_W-1:0]                rr_ptr_q;
    logic [NUM_PORTS-1:0]           rsp_valid_q;
    logic [NUM_PORTS*BUS_WIDTH-1:0] rsp_rdata_q;
    logic [NUM_PORTS-1:0]           arb_loss;
    logic [NUM_PORTS-1:0]           ready;
    logic [NUM_PORTS-1:0]           fire;
    port_idx_t                      winner;
    logic                           collision;

    // With en low nothing can be granted, so no arbitration takes place.
    mp_ram_arb #(
        .NUM_PORTS  (NUM_PORTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_arb (
        .valid     (bus.req_valid & {NUM_PORTS{bus.en}}),
        .we        (bus.req_we),
        .addr      (bus.req_addr),
        .rr_ptr    (port_idx_t'(rr_ptr_q)),
        .arb_loss  (arb_loss),
        .winner    (winner),
        .collision (collision)
    );

    // A read is refused while that port still holds an unconsumed response.
    always_comb begin
        ready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            ready[p] = bus.en && !arb_loss[p] &&
                       !(!bus.req_we[p] && rsp_valid_q[p] && !bus.rsp_ready[p]);
        end
    end

    assign fire          = bus.req_valid & ready;
    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Arbitration guarantees granted writes target distinct addresses.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (fire[p] && bus.req_we[p])
                mem[bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.req_wdata[p*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    // Reads sample mem before this edge's writes land (read-first).
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (fire[p] && !bus.req_we[p]) begin
                    rsp_valid_q[p]                        <= 1'b1;
                    rsp_rdata_q[p*BUS_WIDTH +: BUS_WIDTH] <= mem[bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
                end else if (rsp_valid_q[p] && bus.rsp_ready[p]) begin
                    rsp_valid_q[p] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            rr_ptr_q <= '0;
        else if (collision)
            rr_ptr_q <= RR_W'((int'(winner) + 1) % NUM_PORTS);
    end

`ifdef MP_RAM_COLLISION_CNT_EN
    logic [15:0] coll_cnt_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            coll_cnt_q <= '0;
        else if (collision && coll_cnt_q != 16'hFFFF)
            coll_cnt_q <= coll_cnt_q + 16'd1;
    end

    assign coll_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_mp_ram.sv
// tb_mp_ram: directed scenarios plus randomized traffic for mp_ram, checked
// against a behavioural model (array memory, per-port pending response,
// round-robin pointer). Optional counter checks need MP_RAM_COLLISION_CNT_EN.
module tb_mp_ram;
    import mp_ram_pkg::*;

    localparam int N     = 2;
    localparam int A     = 8;
    localparam int W     = 64;
    localparam int DEPTH = 2 ** A;

    logic clk = 1'b0;
    logic areset;

    always #5 clk = ~clk;

    mp_ram_if #(.NUM_PORTS(N), .ADDR_WIDTH(A), .BUS_WIDTH(W)) bus ();

`ifdef MP_RAM_COLLISION_CNT_EN
    logic [15:0] coll_cnt;
`endif

    mp_ram #(.NUM_PORTS(N), .ADDR_WIDTH(A), .BUS_WIDTH(W)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
`ifdef MP_RAM_COLLISION_CNT_EN
        ,
        .coll_cnt (coll_cnt)
`endif
    );

    // reference model state
    logic [W-1:0] ref_mem [DEPTH];
    logic [N-1:0] exp_valid;
    logic [W-1:0] exp_data [N];
    logic [N-1:0] exp_ready;
    int           ref_rr;
    int           ref_coll;
    int           exp_winner;
    bit           exp_collision;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [A-1:0] addr_of(input int p);
        return bus.req_addr[p*A +: A];
    endfunction

    function automatic logic [W-1:0] rdata_of(input int p);
        return bus.rsp_rdata[p*W +: W];
    endfunction

    // driver tasks
    task automatic idle();
        bus.en        = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = '1;
    endtask

    task automatic set_req(input int p, input bit we, input logic [A-1:0] a, input logic [W-1:0] d);
        bus.req_valid[p]       = 1'b1;
        bus.req_we[p]          = we;
        bus.req_addr[p*A +: A] = a;
        bus.req_wdata[p*W +: W] = d;
    endtask

    task automatic model_reset();
        exp_valid = '0;
        for (int p = 0; p < N; p++) exp_data[p] = '0;
        ref_rr   = 0;
        ref_coll = 0;
    endtask

    // Walk ports in cyclic order from ref_rr; the first write to an address
    // claims it, any later write to the same address is refused.
    task automatic model_arb();
        logic [N-1:0] loss;
        logic [N-1:0] wr;
        int order [N];
        loss = '0;
        for (int k = 0; k < N; k++) order[k] = (ref_rr + k) % N;
        for (int p = 0; p < N; p++) wr[p] = bus.en && bus.req_valid[p] && bus.req_we[p];
        for (int k = 0; k < N; k++)
            for (int j = 0; j < k; j++)
                if (wr[order[k]] && wr[order[j]] && addr_of(order[k]) == addr_of(order[j]))
                    loss[order[k]] = 1'b1;
        exp_collision = (loss != '0);
        exp_winner = -1;
        for (int k = N - 1; k >= 0; k--)
            if (wr[order[k]] && !loss[order[k]])
                for (int q = 0; q < N; q++)
                    if (loss[q] && addr_of(q) == addr_of(order[k])) exp_winner = order[k];
        for (int p = 0; p < N; p++)
            exp_ready[p] = bus.en && !loss[p] &&
                           !(!bus.req_we[p] && exp_valid[p] && !bus.rsp_ready[p]);
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle();
        bit fired [N];
        #1;
        model_arb();
        for (int p = 0; p < N; p++) begin
            chk($sformatf("req_ready[%0d]", p), W'(bus.req_ready[p]), W'(exp_ready[p]));
            chk($sformatf("rsp_valid[%0d]", p), W'(bus.rsp_valid[p]), W'(exp_valid[p]));
            if (exp_valid[p]) chk($sformatf("rsp_rdata[%0d]", p), rdata_of(p), exp_data[p]);
        end
        chk("rr_ptr", W'(dut.rr_ptr_q), W'(ref_rr));
`ifdef MP_RAM_COLLISION_CNT_EN
        chk("coll_cnt", W'(coll_cnt), W'(ref_coll));
`endif
        @(posedge clk);
        for (int p = 0; p < N; p++) begin
            fired[p] = bus.req_valid[p] && exp_ready[p];
            if (fired[p] && !bus.req_we[p]) begin
                exp_valid[p] = 1'b1;
                exp_data[p]  = ref_mem[addr_of(p)];
            end else if (exp_valid[p] && bus.rsp_ready[p]) begin
                exp_valid[p] = 1'b0;
            end
        end
        for (int p = 0; p < N; p++)
            if (fired[p] && bus.req_we[p]) ref_mem[addr_of(p)] = bus.req_wdata[p*W +: W];
        if (exp_collision) begin
            ref_rr = (exp_winner + 1) % N;
            if (ref_coll < 16'hFFFF) ref_coll++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] d;
        // reset state
        areset = 1'b1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp_valid", W'(bus.rsp_valid), W'(0));
        chk("reset_rsp_rdata0", rdata_of(0), '0);
        chk("reset_rsp_rdata1", rdata_of(1), '0);
        chk("reset_rr_ptr", W'(dut.rr_ptr_q), W'(0));
        @(negedge clk);
        areset = 1'b0;

        // fill memory so every later read has a known value
        for (int a = 0; a < DEPTH; a += N) begin
            idle();
            for (int p = 0; p < N; p++) set_req(p, 1'b1, A'(a + p), {$urandom, $urandom});
            cycle();
        end

        // write then read through another port
        idle(); set_req(0, 1'b1, 8'h10, 64'hA5A5); cycle();
        idle(); set_req(1, 1'b0, 8'h10, '0);       cycle();
        idle();
        chk("wr_rd_valid", W'(bus.rsp_valid[1]), W'(1));
        chk("wr_rd_data", rdata_of(1), 64'hA5A5);
        cycle();

        // same-address write collision, round-robin alternation
        idle(); set_req(0, 1'b1, 8'h20, 64'h111); set_req(1, 1'b1, 8'h20, 64'h222);
        #1;
        chk("coll1_ready0", W'(bus.req_ready[0]), W'(1));
        chk("coll1_ready1", W'(bus.req_ready[1]), W'(0));
        cycle();
        chk("coll1_rr", W'(dut.rr_ptr_q), W'(1));
        #1;
        chk("coll2_ready0", W'(bus.req_ready[0]), W'(0));
        chk("coll2_ready1", W'(bus.req_ready[1]), W'(1));
        cycle();
        chk("coll2_rr", W'(dut.rr_ptr_q), W'(0));
        idle(); set_req(0, 1'b0, 8'h20, '0); cycle();
        idle();
        chk("coll2_data", rdata_of(0), 64'h222);
        cycle();

        // read-first on same-edge read/write
        idle(); set_req(0, 1'b1, 8'h30, 64'h1); cycle();
        idle(); set_req(0, 1'b1, 8'h30, 64'h2); set_req(1, 1'b0, 8'h30, '0); cycle();
        idle();
        chk("rdfirst_old", rdata_of(1), 64'h1);
        set_req(0, 1'b0, 8'h30, '0); cycle();
        idle();
        chk("rdfirst_new", rdata_of(0), 64'h2);
        cycle();

        // backpressure: response held, further reads refused
        idle(); set_req(0, 1'b0, 8'h10, '0); bus.rsp_ready[0] = 1'b0; cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); bus.rsp_ready[0] = 1'b0; set_req(0, 1'b0, 8'h11, '0);
            #1;
            chk("bp_ready", W'(bus.req_ready[0]), W'(0));
            chk("bp_valid", W'(bus.rsp_valid[0]), W'(1));
            chk("bp_data", rdata_of(0), 64'hA5A5);
            cycle();
        end
        idle(); cycle();
        chk("bp_drained", W'(bus.rsp_valid[0]), W'(0));

        // asynchronous reset with a pending response
        idle(); set_req(0, 1'b0, 8'h10, '0); bus.rsp_ready[0] = 1'b0; cycle();
        idle(); bus.rsp_ready[0] = 1'b0;
        #2 areset = 1'b1;
        #1;
        chk("areset_valid", W'(bus.rsp_valid), W'(0));
        chk("areset_data", rdata_of(0), '0);
        model_reset();
        @(negedge clk);
        areset = 1'b0;
        idle(); set_req(1, 1'b0, 8'h10, '0); cycle();
        idle();
        chk("mem_kept", rdata_of(1), 64'hA5A5);
        cycle();

        // randomized traffic, small address window to provoke collisions
        for (int i = 0; i < 1500; i++) begin
            idle();
            bus.en = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    d = {$urandom, $urandom};
                    set_req(p, ($urandom_range(0, 1) != 0), A'($urandom_range(0, 7)), d);
                end
                bus.rsp_ready[p] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        idle(); cycle(); cycle();

`ifdef MP_RAM_COLLISION_CNT_EN
        areset = 1'b1;
        #2;
        model_reset();
        @(negedge clk);
        areset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(); set_req(0, 1'b1, 8'h50, W'(i)); set_req(1, 1'b1, 8'h50, W'(i + 100));
            cycle();
        end
        chk("coll_cnt_5", W'(coll_cnt), W'(5));
        idle(); set_req(0, 1'b1, 8'h50, '0); set_req(1, 1'b1, 8'h50, '1);
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("coll_cnt_sat", W'(coll_cnt), W'(16'hFFFF));
        idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mp_ram.md
MP_RAM -- requirements
Module: mp_ram

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of independent access ports (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; memory depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter BUS_WIDTH, default 64, data word width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  global enable; when 0, no request is accepted.
REQ-007 SHALL have port req_valid  input  NUM_PORTS  per-port request valid.
REQ-008 SHALL have port req_ready  output  NUM_PORTS  per-port request accepted this cycle.
REQ-009 SHALL have port req_we  input  NUM_PORTS  per-port write (1) or read (0).
REQ-010 SHALL have port req_addr  input  NUM_PORTS*ADDR_WIDTH  per-port address; port p at slice p.
REQ-011 SHALL have port req_wdata  input  NUM_PORTS*BUS_WIDTH  per-port write data.
REQ-012 SHALL have port rsp_valid  output  NUM_PORTS  per-port read data valid.
REQ-013 SHALL have port rsp_ready  input  NUM_PORTS  per-port read data consumed.
REQ-014 SHALL have port rsp_rdata  output  NUM_PORTS*BUS_WIDTH  per-port read data.

Function
REQ-015 SHALL accept a request on port p when req_valid[p] && req_ready[p] (transfer) at a rising clk edge.
REQ-016 SHALL drive req_ready[p] = en && !arb_loss[p] && !(req_we[p]==0 && rsp_valid[p] && !rsp_ready[p]); req_ready is combinational.
REQ-017 SHALL commit an accepted write to memory at the accepting edge; writes generate no response.
REQ-018 SHALL present read data for an accepted read on rsp_rdata[p] with rsp_valid[p]=1 exactly one cycle after acceptance.
REQ-019 SHALL hold rsp_valid[p] and rsp_rdata[p] stable until rsp_valid[p] && rsp_ready[p]; rsp_valid[p] then clears unless a new read is accepted on the same edge.
REQ-020 SHALL sustain one read per port per cycle when rsp_ready is held high (back-to-back).
REQ-021 SHALL grant all simultaneous reads, including reads of the same address.
REQ-022 SHALL, on read and write to the same address on the same edge (different ports), return the pre-write data (read-first).
REQ-023 SHALL, on two or more valid writes to the same address in one cycle, grant exactly one: the first such port at or after rr_ptr in cyclic order; the losers see arb_loss=1 (req_ready=0).
REQ-024 SHALL advance rr_ptr to (winner+1) mod NUM_PORTS only on a cycle with a write-write collision; otherwise hold rr_ptr.
REQ-025 SHALL not stall writes to distinct addresses; with en=0 SHALL accept nothing but still let pending responses drain.
REQ-026 SHALL treat X-free addresses only; behaviour for NUM_PORTS=1 degenerates to no arbitration.

Reset
REQ-027 SHALL, while areset=1, force rsp_valid=0, rsp_rdata=0, rr_ptr=0 and the collision counter=0 immediately, independent of clk.
REQ-028 SHALL discard any pending response on reset mid-operation; memory contents SHALL NOT be reset.
REQ-029 SHALL accept requests from the first rising edge after areset deasserts.

Configuration
REQ-030 SHALL, with MP_RAM_COLLISION_CNT_EN defined, add output coll_cnt (16 bits) counting cycles with at least one write-write collision, saturating at 16'hFFFF.
REQ-031 SHALL, without MP_RAM_COLLISION_CNT_EN, omit the coll_cnt port and its logic; all other behaviour identical.

Structure
REQ-032 SHALL place default parameter constants, the port-index type and the rr-pointer width function in package mp_ram_pkg.
REQ-033 SHALL implement the collision arbiter as sub-module mp_ram_arb (inputs valid, we, addresses, rr_ptr; outputs arb_loss, winner, collision).

Verification
REQ-034 SHALL cover: port0 write addr 0x10 data 0xA5A5, next cycle port1 read 0x10 -> rsp_valid[1] one cycle later, rsp_rdata=0xA5A5.
REQ-035 SHALL cover: ports 0 and 1 write addr 0x20 same cycle, rr_ptr=0 -> port0 wins, req_ready[1]=0, rr_ptr=1; repeat -> port1 wins, rr_ptr=0.
REQ-036 SHALL cover: mem[0x30]=0x1, port0 writes 0x2 and port1 reads 0x30 same edge -> rsp_rdata[1]=0x1, later read returns 0x2.
REQ-037 SHALL cover: port0 read with rsp_ready[0]=0 for 3 cycles -> rsp_valid held, req_ready[0]=0 for reads, data stable; rsp_ready=1 -> drains.
REQ-038 SHALL cover: areset pulse with rsp_valid=1 -> rsp_valid=0 asynchronously; mem[0x10] still 0xA5A5 after reset.
REQ-039 SHALL cover with MP_RAM_COLLISION_CNT_EN: 5 collision cycles -> coll_cnt=5; saturation at 16'hFFFF.
